// File: rtl/pipelined_datapath_param_if.sv
// Instruction/data memory bus between the datapath (master) and combinational-read memories (slave).
// Reads are same-cycle; stores commit on the rising clock edge while dmem_we is high.
interface pipelined_datapath_param_if #(
    parameter int DATA_W  = 32,
    parameter int IMEM_AW = 9,
    parameter int DMEM_AW = 8
);
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_rdata;
    logic [DMEM_AW-1:0] dmem_addr;
    logic               dmem_we;
    logic [DATA_W-1:0]  dmem_wdata;
    logic [DATA_W-1:0]  dmem_rdata;

    modport master (
        output imem_addr, dmem_addr, dmem_we, dmem_wdata,
        input  imem_rdata, dmem_rdata
    );

    modport slave (
        input  imem_addr, dmem_addr, dmem_we, dmem_wdata,
        output imem_rdata, dmem_rdata
    );
endinterface

// File: rtl/pipelined_datapath_param.sv
// Five-stage integer pipeline with ALU, 8-entry register file, forwarding or interlock, load-use stall and HALT drain.
// Latency 5 cycles fetch-to-writeback; a hazard holds PC and IF/ID and sends a bubble into EX.
module pipelined_datapath_param #(
    parameter int DATA_W  = 32,
    parameter int IMEM_AW = 9,
    parameter int DMEM_AW = 8,
    parameter int FWD_EN  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    pipelined_datapath_param_if.master bus,
    input  logic [2:0]                 dbg_raddr,
    output logic [DATA_W-1:0]          dbg_rdata,
    output logic                       halted,
    output logic [31:0]                retired_cnt,
    output logic [31:0]                stall_cnt
);
    typedef logic [DATA_W-1:0] word_t;

    typedef struct packed {
        logic       vld;
        logic       wreg;
        logic       is_load;
        logic       is_store;
        logic       is_halt;
        logic       use1;
        logic       use2;
        logic [3:0] op;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic [2:0] rd;
        logic [4:0] shamt;
        word_t      imm;
    } ctrl_t;

    typedef struct packed {
        ctrl_t c;
        word_t a;
        word_t b;
    } id_ex_t;

    typedef struct packed {
        logic       vld;
        logic       wreg;
        logic       is_load;
        logic       is_store;
        logic       is_halt;
        logic [2:0] rd;
        word_t      res;
        word_t      sdat;
    } ex_mem_t;

    typedef struct packed {
        logic       vld;
        logic       wreg;
        logic       is_halt;
        logic [2:0] rd;
        word_t      res;
    } mem_wb_t;

    function automatic ctrl_t decode(input logic [31:0] ins);
        ctrl_t c;
        c       = '0;
        c.op    = ins[20:17];
        c.rs1   = ins[29:27];
        c.rs2   = ins[26:24];
        c.rd    = ins[23:21];
        c.shamt = ins[10:6];
        c.imm   = word_t'($signed(ins[15:0]));
        if (ins[31]) begin
            c.vld      = 1'b1;
            c.is_store = 1'b1;
            c.use1     = 1'b1;
            c.use2     = 1'b1;
        end else if (ins[30]) begin
            c.vld     = 1'b1;
            c.wreg    = 1'b1;
            c.is_load = (c.op == 4'hE);
            c.use1    = (c.op <= 4'h8) || (c.op == 4'hE);
            c.use2    = (c.op <= 4'h4);
        end else if (c.op == 4'hF) begin
            c.vld     = 1'b1;
            c.is_halt = 1'b1;
        end
        return c;
    endfunction

    logic [IMEM_AW-1:0] pc;
    logic [31:0]        if_id_ins;
    logic               halt_seen;
    id_ex_t             id_ex;
    ex_mem_t            ex_mem;
    mem_wb_t            mem_wb;
    word_t              regs [8];

    ctrl_t idc;
    word_t id_a, id_b, ex_a, ex_b, alu;
    logic  hit_ex, hit_mem, stall, freeze;

    // ID: decode, register read with write-through from WB, hazard detection
    always_comb begin
        idc  = decode(if_id_ins);
        id_a = regs[idc.rs1];
        id_b = regs[idc.rs2];
        if (mem_wb.wreg && mem_wb.rd == idc.rs1) id_a = mem_wb.res;
        if (mem_wb.wreg && mem_wb.rd == idc.rs2) id_b = mem_wb.res;
        hit_ex  = id_ex.c.wreg && ((idc.use1 && id_ex.c.rd == idc.rs1) ||
                                   (idc.use2 && id_ex.c.rd == idc.rs2));
        hit_mem = ex_mem.wreg  && ((idc.use1 && ex_mem.rd == idc.rs1) ||
                                   (idc.use2 && ex_mem.rd == idc.rs2));
        stall   = (FWD_EN != 0) ? (hit_ex && id_ex.c.is_load) : (hit_ex || hit_mem);
        freeze  = halt_seen || idc.is_halt;
    end

    // EX: newest producer wins, so the EX/MEM check overrides MEM/WB
    always_comb begin
        ex_a = id_ex.a;
        ex_b = id_ex.b;
        if (FWD_EN != 0) begin
            if (mem_wb.wreg && mem_wb.rd == id_ex.c.rs1) ex_a = mem_wb.res;
            if (mem_wb.wreg && mem_wb.rd == id_ex.c.rs2) ex_b = mem_wb.res;
            if (ex_mem.wreg && !ex_mem.is_load && ex_mem.rd == id_ex.c.rs1) ex_a = ex_mem.res;
            if (ex_mem.wreg && !ex_mem.is_load && ex_mem.rd == id_ex.c.rs2) ex_b = ex_mem.res;
        end
        case (id_ex.c.op)
            4'h0:       alu = ex_a + ex_b;
            4'h1:       alu = ex_a - ex_b;
            4'h2:       alu = ex_a & ex_b;
            4'h3:       alu = ex_a | ex_b;
            4'h4:       alu = ex_a ^ ex_b;
            4'h5:       alu = (32'(id_ex.c.shamt) >= DATA_W) ? '0 : (ex_a << id_ex.c.shamt);
            4'h6:       alu = (32'(id_ex.c.shamt) >= DATA_W) ? '0 : (ex_a >> id_ex.c.shamt);
            4'h7:       alu = ex_a;
            4'h8, 4'hE: alu = ex_a + id_ex.c.imm;
            default:    alu = '0;
        endcase
        if (id_ex.c.is_store) alu = ex_a + id_ex.c.imm;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc        <= '0;
            if_id_ins <= '0;
            id_ex     <= '0;
            halt_seen <= 1'b0;
        end else if (stall) begin
            id_ex <= '0;
        end else begin
            id_ex.c <= idc;
            id_ex.a <= id_a;
            id_ex.b <= id_b;
            if (freeze) begin
                if_id_ins <= '0;
            end else begin
                if_id_ins <= bus.imem_rdata;
                pc        <= pc + 1'b1;
            end
            if (idc.is_halt) halt_seen <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_mem <= '0;
            mem_wb <= '0;
        end else begin
            ex_mem.vld      <= id_ex.c.vld;
            ex_mem.wreg     <= id_ex.c.wreg;
            ex_mem.is_load  <= id_ex.c.is_load;
            ex_mem.is_store <= id_ex.c.is_store;
            ex_mem.is_halt  <= id_ex.c.is_halt;
            ex_mem.rd       <= id_ex.c.rd;
            ex_mem.res      <= alu;
            ex_mem.sdat     <= ex_b;
            mem_wb.vld      <= ex_mem.vld;
            mem_wb.wreg     <= ex_mem.wreg;
            mem_wb.is_halt  <= ex_mem.is_halt;
            mem_wb.rd       <= ex_mem.rd;
            mem_wb.res      <= ex_mem.is_load ? bus.dmem_rdata : ex_mem.res;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) regs[i] <= '0;
            retired_cnt <= '0;
            stall_cnt   <= '0;
            halted      <= 1'b0;
        end else begin
            if (mem_wb.wreg) regs[mem_wb.rd] <= mem_wb.res;
            if (mem_wb.vld && retired_cnt != '1) retired_cnt <= retired_cnt + 1'b1;
            if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if (mem_wb.is_halt) halted <= 1'b1;
        end
    end

    assign bus.imem_addr  = pc;
    assign bus.dmem_addr  = ex_mem.res[DMEM_AW-1:0];
    assign bus.dmem_we    = ex_mem.is_store;
    assign bus.dmem_wdata = ex_mem.sdat;
    assign dbg_rdata      = regs[dbg_raddr];
endmodule
